// File: rtl/im_sram_banked_mem.sv
// Banked item-memory store: one fold word striped across single-port sync SRAM banks,
// with valid/ready ports, write-over-read arbitration and a 2-entry in-order read skid buffer.
module im_sram_banked_mem #(
    parameter int FOLD_WIDTH      = 500,
    parameter int SRAM_ADDR_WIDTH = 7,
    parameter int DEPTH           = 128,
    parameter int SRAM_WIDTH      = 144
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] wr_addr,
    input  logic [FOLD_WIDTH-1:0]      wr_data,
    input  logic                       rd_req_valid,
    output logic                       rd_req_ready,
    input  logic [SRAM_ADDR_WIDTH-1:0] rd_addr,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [FOLD_WIDTH-1:0]      rd_data,
    output logic                       addr_err
);

    localparam int NUM_BANKS = (FOLD_WIDTH + SRAM_WIDTH - 1) / SRAM_WIDTH;
    localparam int LAST_W    = FOLD_WIDTH - (NUM_BANKS - 1) * SRAM_WIDTH;
    localparam logic [SRAM_ADDR_WIDTH:0] DEPTH_A = (SRAM_ADDR_WIDTH + 1)'(DEPTH);

    logic                       wr_acc, rd_acc, pop, push;
    logic                       wr_in_range, rd_in_range;
    logic                       bank_ceb, bank_web;
    logic [SRAM_ADDR_WIDTH-1:0] bank_addr;
    logic [FOLD_WIDTH-1:0]      bank_q, push_data;
    logic [2:0]                 pending;

    logic [1:0]                 occ_q, occ_d;
    logic                       inflight_q, inflight_d;
    logic                       inflight_oor_q, inflight_oor_d;
    logic                       rd_ptr_q, rd_ptr_d;
    logic                       wr_ptr_q, wr_ptr_d;
    logic                       addr_err_q, addr_err_d;
    logic [FOLD_WIDTH-1:0]      skid_q [2];

    assign wr_ready    = !rst;
    assign wr_acc      = wr_valid && wr_ready;
    assign rd_valid    = (occ_q != 2'd0);
    assign pop         = rd_valid && rd_ready;

    // Slots already committed (buffered + in flight) minus the one leaving this edge.
    assign pending     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_req_ready = !rst && !wr_valid && (pending < 3'd2);
    assign rd_acc      = rd_req_valid && rd_req_ready;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_A);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_A);

    // Out-of-range accesses never enable a bank; such reads are zeroed at the buffer input.
    assign bank_ceb  = !((wr_acc && wr_in_range) || (rd_acc && rd_in_range));
    assign bank_web  = !wr_acc;
    assign bank_addr = wr_acc ? wr_addr : rd_addr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam int WB = (b == NUM_BANKS - 1) ? LAST_W : SRAM_WIDTH;
        logic [WB-1:0] mem [DEPTH];
        logic [WB-1:0] q_q;

        always_ff @(posedge clk) begin
            if (!bank_ceb) begin
                if (!bank_web) begin
                    mem[bank_addr] <= wr_data[b*SRAM_WIDTH +: WB];
                end else begin
                    q_q <= mem[bank_addr];
                end
            end
        end

        assign bank_q[b*SRAM_WIDTH +: WB] = q_q;
    end

    always_comb begin
        push           = inflight_q;
        push_data      = inflight_oor_q ? '0 : bank_q;
        occ_d          = occ_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d       = wr_ptr_q ^ push;
        rd_ptr_d       = rd_ptr_q ^ pop;
        inflight_d     = rd_acc;
        inflight_oor_d = rd_acc && !rd_in_range;
        addr_err_d     = addr_err_q
                       | (wr_acc && !wr_in_range)
                       | (rd_acc && !rd_in_range);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q          <= 2'd0;
            inflight_q     <= 1'b0;
            inflight_oor_q <= 1'b0;
            rd_ptr_q       <= 1'b0;
            wr_ptr_q       <= 1'b0;
            addr_err_q     <= 1'b0;
        end else begin
            occ_q          <= occ_d;
            inflight_q     <= inflight_d;
            inflight_oor_q <= inflight_oor_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            addr_err_q     <= addr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            skid_q[wr_ptr_q] <= push_data;
        end
    end

    // Buffer storage is not reset; gating on rd_valid keeps rd_data at zero when empty.
    assign rd_data  = rd_valid ? skid_q[rd_ptr_q] : '0;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_im_sram_banked_mem.sv
// Scoreboard bench for im_sram_banked_mem built with DEPTH=100 so out-of-range handling is live.
module tb_im_sram_banked_mem;

    localparam int FW  = 500;
    localparam int AW  = 7;
    localparam int DEP = 100;
    localparam int SW  = 144;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [FW-1:0] wr_data;
    logic          rd_req_valid, rd_req_ready;
    logic [AW-1:0] rd_addr;
    logic          rd_valid, rd_ready;
    logic [FW-1:0] rd_data;
    logic          addr_err;

    always #5 clk = ~clk;

    im_sram_banked_mem #(
        .FOLD_WIDTH(FW), .SRAM_ADDR_WIDTH(AW), .DEPTH(DEP), .SRAM_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .addr_err(addr_err)
    );

    int            n_chk = 0;
    int            n_fail = 0;
    int            stalls = 0;
    int            pop_cnt = 0;
    int            pop_first = -1;
    int            pop_last = -1;
    int            cyc = 0;
    logic          prev_stall = 1'b0;
    logic [FW-1:0] prev_data;
    logic [FW-1:0] model [DEP];
    logic [FW-1:0] exp_q [$];

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkint(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pat(input int a);
        logic [511:0] w;
        for (int j = 0; j < 16; j++) w[j*32 +: 32] = {8'(a), 8'(j), 16'h5A3C};
        return w[FW-1:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk1("stall_valid_held", rd_valid, 1'b1);
                chk("stall_data_held", rd_data, prev_data);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk1("rd_valid_unexpected", rd_valid, 1'b0);
                end else begin
                    chk("rd_data", rd_data, exp_q.pop_front());
                    pop_cnt++;
                    if (pop_first < 0) pop_first = cyc;
                    pop_last = cyc;
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [FW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(negedge clk);
        chk1("wr_ready", wr_ready, 1'b1);
        if (int'(a) < DEP) model[a] = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input bit last);
        rd_req_valid = 1'b1;
        rd_addr      = a;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_req_ready) begin
                exp_q.push_back((int'(a) < DEP) ? model[a] : '0);
                tick();
                if (last) rd_req_valid = 1'b0;
                return;
            end
            stalls++;
            tick();
        end
        chk1("rd_accept_timeout", rd_req_ready, 1'b1);
        rd_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chkint("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: time %0t reached, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [503:0] a5w;
        logic [FW-1:0] a5;
        int s0;
        a5w = {63{8'hA5}};
        a5  = a5w[FW-1:0];

        rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b1; rd_addr = '0; rd_ready = 1'b1;
        repeat (3) tick();
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chk1("rst_addr_err", addr_err, 1'b0);
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_rd_req_ready", rd_req_ready, 1'b0);
        chk("rst_rd_data", rd_data, '0);
        rd_req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk1("wr_ready_after_rst", wr_ready, 1'b1);
        tick();

        // Single write/read with bank-boundary checks and latency
        do_write(7'd3, a5);
        do_read(7'd3, 1'b1);
        chk1("latency_not_early", rd_valid, 1'b0);
        tick();
        chk1("latency_valid", rd_valid, 1'b1);
        chk1("bit143", rd_data[143], a5[143]);
        chk1("bit144", rd_data[144], a5[144]);
        chk1("bit287", rd_data[287], a5[287]);
        chk1("bit288", rd_data[288], a5[288]);
        chk1("bit431", rd_data[431], a5[431]);
        chk1("bit432", rd_data[432], a5[432]);
        drain();

        // Back-to-back reads
        for (int a = 0; a < 8; a++) do_write(AW'(a), pat(a));
        do_write(7'd99, pat(99));
        stalls = 0; pop_cnt = 0; pop_first = -1;
        for (int a = 0; a < 8; a++) do_read(AW'(a), a == 7);
        drain();
        chkint("b2b_stalls", stalls, 0);
        chkint("b2b_pops", pop_cnt, 8);
        chkint("b2b_consecutive", pop_last - pop_first, 7);

        // Consumer stall: two accepts then back-pressure
        rd_ready = 1'b0;
        pop_cnt = 0;
        do_read(7'd0, 1'b0);
        do_read(7'd1, 1'b0);
        rd_addr = 7'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rd_req_ready_full", rd_req_ready, 1'b0);
            tick();
        end
        rd_ready = 1'b1;
        do_read(7'd2, 1'b1);
        drain();
        chkint("stall_pops", pop_cnt, 3);

        // Write and read in the same cycle: write wins, read follows
        wr_valid = 1'b1; wr_addr = 7'd10; wr_data = pat(200);
        rd_req_valid = 1'b1; rd_addr = 7'd10;
        @(negedge clk);
        chk1("arb_wr_ready", wr_ready, 1'b1);
        chk1("arb_rd_req_ready", rd_req_ready, 1'b0);
        model[10] = pat(200);
        tick();
        wr_valid = 1'b0;
        s0 = stalls;
        do_read(7'd10, 1'b1);
        chkint("arb_read_next_cycle", stalls - s0, 0);
        drain();

        // Out-of-range write and read
        chk1("addr_err_clear", addr_err, 1'b0);
        do_write(7'd100, pat(238));
        chk1("addr_err_set", addr_err, 1'b1);
        for (int a = 0; a < 8; a++) do_read(AW'(a), 1'b0);
        do_read(7'd99, 1'b0);
        do_read(7'd100, 1'b0);
        do_read(7'd120, 1'b1);
        drain();
        chk1("addr_err_sticky", addr_err, 1'b1);

        // Reset with one word buffered and one in flight
        rd_ready = 1'b0;
        do_read(7'd0, 1'b0);
        do_read(7'd1, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        tick();
        chk1("rst_mid_rd_valid", rd_valid, 1'b0);
        chk1("rst_mid_addr_err", addr_err, 1'b0);
        rst = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("post_rst_idle", rd_valid, 1'b0);
        end
        chk("post_rst_rd_data", rd_data, '0);
        pop_cnt = 0;
        do_read(7'd5, 1'b1);
        drain();
        chkint("post_rst_pops", pop_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
